// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//
// Memory-mapped read peripheral for the board push-buttons. Each raw pin is
// brought into the clk domain through two flops, debounced by a per-button
// counter, and then turned into sticky press/release events plus a running
// 16-bit press count. The CPU sees a 4-word register file behind the bridge.
//
// Ports
//   clk        in   system clock (cpu_clk domain)
//   rst        in   synchronous, active-high reset
//   btn_in     in   [NBTN] raw asynchronous button pins, 1 = pressed
//   wen        in   bridge write strobe, one cycle per write
//   addr       in   [2] register select (bus address bits [3:2])
//   wdata      in   [32] write data from bridge
//   rdata      out  [32] read data, combinational from registers
//   btn_stable out  [NBTN] debounced button levels
//   irq        out  high while any press-pending bit is set
//
// Register map (unused bits read 0)
//   0  btn_stable          read-only, writes ignored
//   1  press_pend          W1C
//   2  release_pend        W1C
//   3  press_cnt[15:0]     any write clears (rises in the same cycle still count)
//
// Bus handshake: wen is a one-cycle strobe with no ready; a write is accepted
// on every clk edge where wen=1, and reads are side-effect free with rdata
// valid in the same cycle addr is presented.
// -----------------------------------------------------------------------------
module button_reader #(
    parameter int NBTN            = 5,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_in,
    input  logic            wen,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NBTN-1:0] btn_stable,
    output logic            irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchroniser and debounce state
    logic [NBTN-1:0]             s1_q;
    logic [NBTN-1:0]             sync_q;
    logic [NBTN-1:0]             stable_q,  stable_d;
    logic [NBTN-1:0][CNT_W-1:0]  cnt_q,     cnt_d;

    // Event and count registers
    logic [NBTN-1:0]             press_pend_q,   press_pend_d;
    logic [NBTN-1:0]             release_pend_q, release_pend_d;
    logic [15:0]                 press_cnt_q,    press_cnt_d;

    logic [NBTN-1:0]             rise;
    logic [NBTN-1:0]             fall;
    logic [15:0]                 rise_cnt;

    logic                        wr_press_pend;
    logic                        wr_release_pend;
    logic                        wr_press_cnt;
    logic [NBTN-1:0]             wmask;

    // Bits of wdata above the button field carry no meaning here.
    logic                        unused_wdata;
    assign unused_wdata = ^wdata[31:NBTN];

    assign wr_press_pend   = wen && (addr == 2'd1);
    assign wr_release_pend = wen && (addr == 2'd2);
    assign wr_press_cnt    = wen && (addr == 2'd3);
    assign wmask           = wdata[NBTN-1:0];

    // Debounce: the counter only runs while the synchronised level disagrees
    // with the accepted level; any agreement restarts it, so a glitch shorter
    // than DEBOUNCE_CYCLES never reaches stable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NBTN; i++) begin
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Edges are taken on the next-state value so events appear in the same
    // cycle btn_stable changes, not one cycle later.
    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    always_comb begin
        rise_cnt = 16'd0;
        for (int i = 0; i < NBTN; i++) begin
            rise_cnt = rise_cnt + 16'(rise[i]);
        end
    end

    // Event registers: the clear is applied first and new events OR-ed in
    // afterwards, so an event coinciding with a W1C on the same bit survives.
    always_comb begin
        press_pend_d   = press_pend_q;
        release_pend_d = release_pend_q;
        press_cnt_d    = press_cnt_q;

        if (wr_press_pend) begin
            press_pend_d = press_pend_d & ~wmask;
        end
        if (wr_release_pend) begin
            release_pend_d = release_pend_d & ~wmask;
        end
        if (wr_press_cnt) begin
            press_cnt_d = 16'd0;
        end

        press_pend_d   = press_pend_d | rise;
        release_pend_d = release_pend_d | fall;
        press_cnt_d    = press_cnt_d + rise_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q           <= '0;
            sync_q         <= '0;
            stable_q       <= '0;
            cnt_q          <= '0;
            press_pend_q   <= '0;
            release_pend_q <= '0;
            press_cnt_q    <= '0;
        end else begin
            s1_q           <= btn_in;
            sync_q         <= s1_q;
            stable_q       <= stable_d;
            cnt_q          <= cnt_d;
            press_pend_q   <= press_pend_d;
            release_pend_q <= release_pend_d;
            press_cnt_q    <= press_cnt_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {{(32-NBTN){1'b0}}, stable_q};
            2'd1:    rdata = {{(32-NBTN){1'b0}}, press_pend_q};
            2'd2:    rdata = {{(32-NBTN){1'b0}}, release_pend_q};
            default: rdata = {16'd0, press_cnt_q};
        endcase
    end

    assign btn_stable = stable_q;
    assign irq        = |press_pend_q;

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Memory-mapped input peripheral for the 5 board push-buttons; the read-side counterpart of the write-only LED and 7-seg outputs on the bridge.
- Synchronises and debounces each button, then latches sticky press/release events and keeps a running press count.
- Sits behind the bridge and presents a small register file that the CPU reads, plus writes for event clearing. Drives an interrupt-style level flag.

Parameters:
- NBTN, 5, number of buttons (1..16).
- DEBOUNCE_CYCLES, 200000, consecutive clk cycles a new level must persist before it is accepted (>=2).
- CNT_W, 18, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock (cpu_clk domain).
- rst  input  1  synchronous, active-high reset.
- btn_in  input  NBTN  raw asynchronous button pins, 1 = pressed.
- wen  input  1  bridge write strobe, one cycle per write.
- addr  input  2  register select (bus address bits [3:2]).
- wdata  input  32  write data from bridge.
- rdata  output  32  read data to bridge, combinational from registers.
- btn_stable  output  NBTN  debounced button levels.
- irq  output  1  high while any press-pending bit is set.

Behaviour:
- Reset (rst=1 at a clk edge): synchroniser flops, debounce counters, btn_stable, press_pend, release_pend and press_cnt all go to 0. irq=0. rdata reflects the zeroed registers.
- Synchroniser: two flops per button, s1 <= btn_in, sync <= s1. There is no reset-free path.
- Debounce, per button, evaluated every edge:
  - If sync == stable, the counter is set to 0.
  - Else if counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0.
  - Otherwise counter increments.
  - Pin-to-btn_stable latency is exactly 2 + DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge events:
  - rise = stable transitions 0->1 this edge; fall = stable transitions 1->0 this edge.
  - press_pend[i] is set on rise[i]. release_pend[i] is set on fall[i].
- press_cnt: 16-bit counter. It increments by popcount(rise) each edge (multiple simultaneous rises all count) and wraps modulo 2^16.
- Register map (addr), read returns with unused bits 0:
  - 0: btn_stable in [NBTN-1:0]. Writes are ignored.
  - 1: press_pend. Write is W1C: press_pend &= ~wdata[NBTN-1:0].
  - 2: release_pend. W1C, same rule as addr 1.
  - 3: press_cnt in [15:0]. Any write clears it to 0.
- Simultaneous events:
  - A W1C in the same cycle as a new rise/fall on the same bit leaves the bit set (set wins). Other bits are still cleared.
  - A press_cnt clear in the same cycle as rises loads popcount(rise), not 0.
- Reads have no side effects. wen and addr are sampled only at clk edges. rdata is valid in the same cycle addr is presented (single-cycle bus, like DRAM spo).
- irq = |press_pend, registered state only, with no extra latency beyond press_pend.
- Reset mid-operation: all in-flight debounce progress is discarded.
  - A button held through reset is seen as a new press after reset deasserts.
  - That press sets stable after 2 + DEBOUNCE_CYCLES edges and sets press_pend and press_cnt=1.
- NBTN < 16: bits above NBTN-1 always read 0 and ignore writes.

Test Plan:
(All with DEBOUNCE_CYCLES=4, NBTN=5.)
1. Reset then btn_in=5'b00001 held.
   - btn_stable[0] rises after exactly edge 6 post-change.
   - addr0 reads 0x1, addr1 reads 0x1, addr3 reads 0x1, irq=1.
2. btn_in[1] pulsed high for 3 cycles, then low.
   - btn_stable stays 0, press_pend=0, press_cnt unchanged, irq=0.
3. After scenario 1, write addr1 wdata=0x1: press_pend=0 and irq=0 next cycle.
   - Repeat with the write landing on the same edge as a new rise of bit 0: press_pend[0] remains 1.
4. Release button 0 after scenario 1.
   - btn_stable[0]=0 after 6 edges, addr2 reads 0x1.
   - Write addr2 0x1 and it reads 0x0.
5. btn_in 0 -> 5'b10100 in a single cycle: after 6 edges press_cnt increments by 2 and addr1 reads 0x14.
   - Write addr3 in the cycle of a single rise: press_cnt reads 1.
6. Assert rst for 1 cycle at debounce counter=2 with btn_in[2]=1 held.
   - Registers read 0 during and after reset.
   - btn_stable[2] rises 6 edges after rst deasserts, and press_cnt=1.
